// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter.
// Word width comes from the core-wide WORD define.
`ifndef WORD
`define WORD 31:0
`endif

package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_if.sv
// Fetch, data and memory-side signals of the arbiter.
// The slave side is the arbiter; the master side is core plus memory.
`ifndef WORD
`define WORD 31:0
`endif

interface mem_arb_if;
  logic         if_req;
  logic [`WORD] if_addr;
  logic         if_gnt;
  logic         if_rvalid;
  logic [`WORD] if_rdata;
  logic         d_req;
  logic         d_we;
  logic [`WORD] d_addr;
  logic [`WORD] d_wdata;
  logic         d_gnt;
  logic         d_rvalid;
  logic [`WORD] d_rdata;
  logic         mem_en;
  logic         mem_we;
  logic [`WORD] mem_addr;
  logic [`WORD] mem_wdata;
  logic [`WORD] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_starve_ctr.sv
// Saturating count of data grants that bypassed a waiting fetch.

module arb_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic sat_o
);
  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] MAX = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_o = (cnt_q == MAX);
endmodule

// File: rtl/mem_arbiter.sv
// One-outstanding arbiter sharing a unified memory between fetch and data.
// Data wins unless fetch has been bypassed STARVE_LIMIT times in a row.

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_arb_if.slave  bus
);
  localparam int unsigned CW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(MEM_LAT);

  arb_state_e    state_q;
  arb_owner_e    owner_q;
  logic          we_q;
  logic [CW-1:0] cnt_q;

  logic starve_sat;
  logic done;
  logic free;
  logic pick_d;
  logic pick_if;
  logic issue;
  logic rv_if;
  logic rv_d;

  assign done    = (state_q == ARB_BUSY) && (cnt_q == LAT);
  assign free    = (state_q == ARB_IDLE) || done;
  assign pick_d  = free && bus.d_req
                && !(bus.if_req && starve_sat);
  assign pick_if = free && bus.if_req && !pick_d;
  assign issue   = pick_d || pick_if;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      cnt_q   <= '0;
    end else if (issue) begin
      state_q <= ARB_BUSY;
      owner_q <= pick_d ? OWN_D : OWN_IF;
      we_q    <= pick_d && bus.d_we;
      cnt_q   <= CW'(1);
    end else if (state_q == ARB_BUSY) begin
      if (done) begin
        state_q <= ARB_IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end
  end

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (pick_if || !bus.if_req),
    .inc_i (pick_d && bus.if_req),
    .sat_o (starve_sat)
  );

  // Every output is gated so nothing escapes while reset is held.
  assign rv_if = rst_n && done && (owner_q == OWN_IF);
  assign rv_d  = rst_n && done && (owner_q == OWN_D);

  assign bus.if_gnt    = rst_n && pick_if;
  assign bus.d_gnt     = rst_n && pick_d;
  assign bus.mem_en    = rst_n && issue;
  assign bus.mem_we    = rst_n && pick_d && bus.d_we;
  assign bus.mem_addr  = !rst_n  ? '0
                       : pick_d  ? bus.d_addr
                       : pick_if ? bus.if_addr
                       : '0;
  assign bus.mem_wdata = (rst_n && pick_d) ? bus.d_wdata : '0;

  assign bus.if_rvalid = rv_if;
  assign bus.if_rdata  = rv_if ? bus.mem_rdata : '0;
  assign bus.d_rvalid  = rv_d;
  assign bus.d_rdata   = (rv_d && !we_q) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters with MEM_LAT 1, 2, 3 on a shared clock,
// each backed by a small memory model where unwritten words read as their address.

module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_n, if_req, d_req, d_we;
  logic [2:0] if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_addr [3];
  logic [31:0] d_addr [3];
  logic [31:0] d_wdata [3];
  logic [31:0] if_rdata [3];
  logic [31:0] d_rdata [3];
  logic [31:0] mem_addr [3];
  logic [31:0] mem_wdata [3];

  int total = 0;
  int passed = 0;

  for (genvar g = 0; g < 3; g++) begin : u
    mem_arb_if bus ();

    mem_arbiter #(
      .MEM_LAT      (g + 1),
      .STARVE_LIMIT (4)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n[g]),
      .bus   (bus)
    );

    assign bus.if_req  = if_req[g];
    assign bus.if_addr = if_addr[g];
    assign bus.d_req   = d_req[g];
    assign bus.d_we    = d_we[g];
    assign bus.d_addr  = d_addr[g];
    assign bus.d_wdata = d_wdata[g];

    assign if_gnt[g]    = bus.if_gnt;
    assign if_rvalid[g] = bus.if_rvalid;
    assign if_rdata[g]  = bus.if_rdata;
    assign d_gnt[g]     = bus.d_gnt;
    assign d_rvalid[g]  = bus.d_rvalid;
    assign d_rdata[g]   = bus.d_rdata;
    assign mem_en[g]    = bus.mem_en;
    assign mem_we[g]    = bus.mem_we;
    assign mem_addr[g]  = bus.mem_addr;
    assign mem_wdata[g] = bus.mem_wdata;

    logic [31:0]  wmem [256];
    logic [255:0] wvld = '0;
    logic [31:0]  pipe [g + 1];
    logic [7:0]   idx;
    logic         pend_if = 1'b0;
    logic         pend_d = 1'b0;

    assign idx = bus.mem_addr[9:2];
    assign bus.mem_rdata = pipe[g];

    always @(posedge clk) begin
      if (bus.mem_en)
        pipe[0] <= wvld[idx] ? wmem[idx] : {22'd0, idx, 2'b00};
      else
        pipe[0] <= '0;
      for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
      if (bus.mem_en && bus.mem_we) begin
        wmem[idx] <= bus.mem_wdata;
        wvld[idx] <= 1'b1;
      end
    end

    // Requester rule: a pending request may not drop before its grant.
    always @(posedge clk) begin
      if ((pend_if && !bus.if_req) || (pend_d && !bus.d_req)) begin
        total++;
        $error("FAIL proto u%0d: request dropped before grant", g);
      end
      pend_if <= rst_n[g] && bus.if_req && !bus.if_gnt;
      pend_d  <= rst_n[g] && bus.d_req && !bus.d_gnt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  initial begin
    logic ed;
    rst_n  = 3'b000;
    if_req = 3'b000;
    d_req  = 3'b000;
    d_we   = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if_addr[i] = '0;
      d_addr[i]  = '0;
      d_wdata[i] = '0;
    end

    // Power-up reset on u0 with both requests already high
    if_req[0] = 1'b1;
    d_req[0]  = 1'b1;
    d_addr[0] = 32'h100;
    for (int i = 0; i < 2; i++) begin
      smp;
      chk("rst_gnt", {30'd0, if_gnt[0], d_gnt[0]}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en[0]}, 32'd0);
      chk("rst_rvalid", {30'd0, if_rvalid[0], d_rvalid[0]}, 32'd0);
      tick;
    end
    rst_n = 3'b111;

    // Starvation guard, MEM_LAT=1: D,D,D,D,IF repeating
    for (int c = 0; c < 11; c++) begin
      ed = ((c % 5) != 4);
      smp;
      chk($sformatf("starve_dgnt_c%0d", c), {31'd0, d_gnt[0]}, {31'd0, ed});
      chk($sformatf("starve_ifgnt_c%0d", c), {31'd0, if_gnt[0]}, {31'd0, !ed});
      if (c > 0) begin
        chk($sformatf("starve_drv_c%0d", c), {31'd0, d_rvalid[0]},
            {31'd0, ((c - 1) % 5) != 4});
        chk($sformatf("starve_ifrv_c%0d", c), {31'd0, if_rvalid[0]},
            {31'd0, ((c - 1) % 5) == 4});
      end
      tick;
    end
    d_req[0] = 1'b0;

    // Back-to-back fetches 0x0, 0x4, 0x8 at MEM_LAT=1
    smp;
    chk("f0_gnt", {31'd0, if_gnt[0]}, 32'd1);
    chk("f0_addr", mem_addr[0], 32'h0);
    chk("f0_drv", {31'd0, d_rvalid[0]}, 32'd1);
    chk("f0_drdata", d_rdata[0], 32'h100);
    tick;
    if_addr[0] = 32'h4;
    smp;
    chk("f1_gnt", {31'd0, if_gnt[0]}, 32'd1);
    chk("f1_addr", mem_addr[0], 32'h4);
    chk("f1_rv", {31'd0, if_rvalid[0]}, 32'd1);
    chk("f1_rdata", if_rdata[0], 32'h0);
    tick;
    if_addr[0] = 32'h8;
    smp;
    chk("f2_gnt", {31'd0, if_gnt[0]}, 32'd1);
    chk("f2_rdata", if_rdata[0], 32'h4);
    tick;
    if_req[0] = 1'b0;
    smp;
    chk("f3_gnt", {31'd0, if_gnt[0]}, 32'd0);
    chk("f3_idle_bus", {30'd0, mem_en[0], mem_we[0]}, 32'd0);
    chk("f3_idle_addr", mem_addr[0], 32'h0);
    chk("f3_rv", {31'd0, if_rvalid[0]}, 32'd1);
    chk("f3_rdata", if_rdata[0], 32'h8);
    tick;
    smp;
    chk("f4_rv", {31'd0, if_rvalid[0]}, 32'd0);
    chk("f4_rdata", if_rdata[0], 32'h0);

    // MEM_LAT=2: simultaneous requests, data first
    tick;
    if_req[1]  = 1'b1;
    if_addr[1] = 32'h40;
    d_req[1]   = 1'b1;
    d_addr[1]  = 32'h100;
    smp;
    chk("l2_c0_dgnt", {31'd0, d_gnt[1]}, 32'd1);
    chk("l2_c0_ifgnt", {31'd0, if_gnt[1]}, 32'd0);
    chk("l2_c0_addr", mem_addr[1], 32'h100);
    tick;
    d_req[1] = 1'b0;
    smp;
    chk("l2_c1_busy", {29'd0, if_gnt[1], d_gnt[1], d_rvalid[1]}, 32'd0);
    tick;
    smp;
    chk("l2_c2_drv", {31'd0, d_rvalid[1]}, 32'd1);
    chk("l2_c2_drdata", d_rdata[1], 32'h100);
    chk("l2_c2_ifgnt", {31'd0, if_gnt[1]}, 32'd1);
    chk("l2_c2_addr", mem_addr[1], 32'h40);
    tick;
    if_req[1] = 1'b0;
    smp;
    chk("l2_c3_ifrv", {31'd0, if_rvalid[1]}, 32'd0);
    tick;
    smp;
    chk("l2_c4_ifrv", {31'd0, if_rvalid[1]}, 32'd1);
    chk("l2_c4_ifrdata", if_rdata[1], 32'h40);

    // Store then reload, MEM_LAT=2
    tick;
    d_req[1]   = 1'b1;
    d_we[1]    = 1'b1;
    d_addr[1]  = 32'h20;
    d_wdata[1] = 32'hDEADBEEF;
    smp;
    chk("st_gnt", {31'd0, d_gnt[1]}, 32'd1);
    chk("st_we", {31'd0, mem_we[1]}, 32'd1);
    chk("st_addr", mem_addr[1], 32'h20);
    chk("st_wdata", mem_wdata[1], 32'hDEADBEEF);
    tick;
    d_req[1]   = 1'b0;
    d_we[1]    = 1'b0;
    d_wdata[1] = '0;
    smp;
    chk("st_wait", {31'd0, d_rvalid[1]}, 32'd0);
    tick;
    d_req[1] = 1'b1;
    smp;
    chk("st_ack", {31'd0, d_rvalid[1]}, 32'd1);
    chk("st_ack_data", d_rdata[1], 32'h0);
    chk("ld_gnt", {31'd0, d_gnt[1]}, 32'd1);
    chk("ld_we", {31'd0, mem_we[1]}, 32'd0);
    tick;
    d_req[1] = 1'b0;
    smp;
    tick;
    smp;
    chk("ld_rv", {31'd0, d_rvalid[1]}, 32'd1);
    chk("ld_data", d_rdata[1], 32'hDEADBEEF);

    // MEM_LAT=3: reset mid-fetch drops it
    tick;
    if_req[2]  = 1'b1;
    if_addr[2] = 32'h4;
    smp;
    chk("mr_ifgnt", {31'd0, if_gnt[2]}, 32'd1);
    tick;
    if_req[2] = 1'b0;
    smp;
    tick;
    rst_n[2]  = 1'b0;
    d_req[2]  = 1'b1;
    d_addr[2] = 32'h100;
    smp;
    chk("mr_outs", {26'd0, if_gnt[2], d_gnt[2], mem_en[2], mem_we[2],
                    if_rvalid[2], d_rvalid[2]}, 32'd0);
    chk("mr_addr", mem_addr[2], 32'h0);
    chk("mr_rdata", if_rdata[2], 32'h0);
    tick;
    rst_n[2] = 1'b1;
    smp;
    chk("mr_post_ifrv", {31'd0, if_rvalid[2]}, 32'd0);
    chk("mr_post_dgnt", {31'd0, d_gnt[2]}, 32'd1);
    tick;
    d_req[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp;
      chk($sformatf("mr_ifrv_k%0d", k), {31'd0, if_rvalid[2]}, 32'd0);
      chk($sformatf("mr_drv_k%0d", k), {31'd0, d_rvalid[2]},
          {31'd0, k == 2});
      chk($sformatf("mr_drdata_k%0d", k), d_rdata[2],
          (k == 2) ? 32'h100 : 32'h0);
      tick;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous memory between the cpu instruction-fetch port and its data port, which the core exposes as separate `instr` and `readData` paths.
- Serialises accesses with one transaction outstanding and fixed memory latency; data accesses have priority, with a starvation guard for fetch.
- Sits between the cpu top level and a unified instruction/data memory; owner stall logic consumes the gnt and rvalid signals.

Parameters:
- MEM_LAT, 1, memory read latency in cycles (>=1); mem_rdata valid MEM_LAT cycles after the issue edge.
- STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  `WORD  fetch address
- if_gnt  out  1  fetch issued to memory this cycle
- if_rvalid  out  1  fetch data valid this cycle
- if_rdata  out  `WORD  fetch data
- d_req  in  1  data request; held stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  `WORD  data address
- d_wdata  in  `WORD  store data
- d_gnt  out  1  data access issued this cycle
- d_rvalid  out  1  load data or store ack valid this cycle
- d_rdata  out  `WORD  load data; 0 on store ack
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  `WORD  memory address
- mem_wdata  out  `WORD  memory write data
- mem_rdata  in  `WORD  memory read data

Behaviour:
- States: IDLE (slot free) and BUSY (waiting). Registers: state, owner, we_q, cnt (counts 1..MEM_LAT), starve.
- Slot free when state==IDLE, or when state==BUSY and cnt==MEM_LAT (completion cycle). A free slot may issue in the same cycle.
- Issue is combinational in a free-slot cycle:
  - pick = D if d_req and !(if_req and starve==STARVE_LIMIT); else IF if if_req; else none.
  - Winner's gnt=1 and mem_en=1. mem_addr/mem_we/mem_wdata come from the winner; mem_we=0 and mem_wdata=0 for IF.
- Issue edge: state<=BUSY, cnt<=1, owner<=pick, we_q<=d_we (0 for IF).
- BUSY with cnt<MEM_LAT: cnt<=cnt+1; no gnt.
- Completion cycle (BUSY, cnt==MEM_LAT):
  - Owner's rvalid=1.
  - rdata=mem_rdata for loads/fetch; d_rdata=0 for a store ack.
  - If nothing issues this cycle, state<=IDLE.
- Throughput: one access per MEM_LAT cycles. MEM_LAT=1 gives a grant every cycle with full back-to-back operation.
- Starvation counter:
  - starve<=starve+1 (saturating at STARVE_LIMIT) on a D grant while if_req=1.
  - starve<=0 on an IF grant, or in any cycle with if_req=0.
- Idle outputs: when no grant, mem_en=mem_we=0 and mem_addr=mem_wdata=0. Non-owner rvalid=0 and rdata=0.
- Simultaneous completion and new issue in one cycle: both are legal; rvalid goes to the old owner and gnt to the new one.
- Reset (rst_n=0 at an edge): state<=IDLE, cnt<=0, owner<=IF, we_q<=0, starve<=0.
  - While rst_n=0, all outputs are forced to 0.
  - An in-flight access is dropped with no rvalid ever produced; a memory write already issued is not undone.
- Requester rule: a request deasserted before its gnt is a protocol violation. The bench asserts this; the RTL does not check it.

Decomposition:
- Package mem_arb_pkg: state enum {ARB_IDLE, ARB_BUSY}, owner enum {OWN_IF, OWN_D}.
- Widths use the existing `WORD define.
- One natural sub-module: arb_starve_ctr (saturating counter with clear, width $clog2(STARVE_LIMIT+1)).
- The latency counter stays inline.

Test Plan:
- MEM_LAT=1, if_req only, if_addr 0x0,0x4,0x8 → if_gnt on 3 consecutive cycles; if_rvalid the following 3 cycles with data 0x0/0x4/0x8 from a model memory (mem[a]=a).
- MEM_LAT=2, if_req and d_req (load 0x100) asserted together → d_gnt in cycle 0; d_rvalid in cycle 2 with data 0x100; if_gnt in cycle 2; if_rvalid in cycle 4.
- Store d_we=1, addr 0x20, wdata 0xDEADBEEF → mem_we=1 on the grant cycle; d_rvalid ack after MEM_LAT with d_rdata=0; a later load of 0x20 returns 0xDEADBEEF.
- STARVE_LIMIT=4, d_req and if_req held continuously → grant pattern D,D,D,D,IF repeating; starve returns to 0 after each IF grant.
- MEM_LAT=3, rst_n pulsed low in cnt==2 of a fetch → no if_rvalid; all outputs 0 during reset; the first grant after release goes to a pending d_req.
- rst_n low at power-up for 2 cycles with both requests high → no gnt, mem_en=0 throughout; grants begin the first cycle with rst_n=1.
